// File: rtl/exu_oitf_gen.sv
// Outstanding-instruction tracking FIFO: one entry per in-flight long-pipe instruction,
// in-order retire, RAW/WAW hazard reporting to dispatch, flush and sticky error flag.
module exu_oitf_gen #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PTR_W   = $clog2(DEPTH),
   parameter int unsigned RFIDX_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,

   input  logic               disp_ena,
   output logic               disp_ready,
   output logic [PTR_W-1:0]   disp_ptr,
   input  logic               disp_i_rs1en,
   input  logic               disp_i_rs2en,
   input  logic               disp_i_rdwen,
   input  logic [RFIDX_W-1:0] disp_i_rs1idx,
   input  logic [RFIDX_W-1:0] disp_i_rs2idx,
   input  logic [RFIDX_W-1:0] disp_i_rdidx,
   output logic               oitfrd_match_disprs1,
   output logic               oitfrd_match_disprs2,
   output logic               oitfrd_match_disprd,

   input  logic               ret_ena,
   output logic [PTR_W-1:0]   ret_ptr,
   output logic [RFIDX_W-1:0] ret_rdidx,
   output logic               ret_rdwen,

   input  logic               flush_req,
   output logic               oitf_empty,
   output logic               oitf_full,
   output logic [PTR_W:0]     oitf_count,
   output logic               oitf_err
);

   logic [PTR_W-1:0]   alc_ptr_q, alc_ptr_d, ret_ptr_q, ret_ptr_d;
   logic               alc_flg_q, alc_flg_d, ret_flg_q, ret_flg_d;
   logic [DEPTH-1:0]   vld_q, vld_d;
   logic [DEPTH-1:0]   rdwen_q;
   logic [RFIDX_W-1:0] rdidx_q [DEPTH];
   logic [PTR_W:0]     cnt_q, cnt_d;
   logic               err_q, err_d;

   logic empty, full, alc_fire, ret_fire;
   logic rs1_hit, rs2_hit, rd_hit;

   localparam logic [PTR_W-1:0] LastIdx = PTR_W'(DEPTH - 1);

   assign empty    = (alc_ptr_q == ret_ptr_q) && (alc_flg_q == ret_flg_q);
   assign full     = (alc_ptr_q == ret_ptr_q) && (alc_flg_q != ret_flg_q);
   // Flush overrides both requests; full/empty block their respective side only.
   assign alc_fire = disp_ena && !full && !flush_req;
   assign ret_fire = ret_ena && !empty && !flush_req;

   always_comb begin
      alc_ptr_d = alc_ptr_q;
      alc_flg_d = alc_flg_q;
      ret_ptr_d = ret_ptr_q;
      ret_flg_d = ret_flg_q;
      vld_d     = vld_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      if (flush_req) begin
         alc_ptr_d = '0;
         alc_flg_d = 1'b0;
         ret_ptr_d = '0;
         ret_flg_d = 1'b0;
         vld_d     = '0;
         cnt_d     = '0;
      end else begin
         if ((disp_ena && full) || (ret_ena && empty)) begin
            err_d = 1'b1;
         end
         if (ret_fire) begin
            vld_d[ret_ptr_q] = 1'b0;
            ret_ptr_d        = ret_ptr_q + 1'b1;
            if (ret_ptr_q == LastIdx) ret_flg_d = ~ret_flg_q;
         end
         if (alc_fire) begin
            vld_d[alc_ptr_q] = 1'b1;
            alc_ptr_d        = alc_ptr_q + 1'b1;
            if (alc_ptr_q == LastIdx) alc_flg_d = ~alc_flg_q;
         end
         unique case ({alc_fire, ret_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alc_ptr_q <= '0;
         alc_flg_q <= 1'b0;
         ret_ptr_q <= '0;
         ret_flg_q <= 1'b0;
         vld_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         alc_ptr_q <= alc_ptr_d;
         alc_flg_q <= alc_flg_d;
         ret_ptr_q <= ret_ptr_d;
         ret_flg_q <= ret_flg_d;
         vld_q     <= vld_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdwen_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) rdidx_q[i] <= '0;
      end else if (alc_fire) begin
         rdwen_q[alc_ptr_q] <= disp_i_rdwen;
         rdidx_q[alc_ptr_q] <= disp_i_rdidx;
      end
   end

   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      rd_hit  = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && rdwen_q[i]) begin
            if (rdidx_q[i] == disp_i_rs1idx) rs1_hit = 1'b1;
            if (rdidx_q[i] == disp_i_rs2idx) rs2_hit = 1'b1;
            if (rdidx_q[i] == disp_i_rdidx)  rd_hit  = 1'b1;
         end
      end
   end

   // x0 is hardwired zero, so it can never carry a hazard.
   assign oitfrd_match_disprs1 = rs1_hit && disp_i_rs1en && (disp_i_rs1idx != '0);
   assign oitfrd_match_disprs2 = rs2_hit && disp_i_rs2en && (disp_i_rs2idx != '0);
   assign oitfrd_match_disprd  = rd_hit  && disp_i_rdwen && (disp_i_rdidx  != '0);

   assign disp_ready = !full;
   assign disp_ptr   = alc_ptr_q;
   assign ret_ptr    = ret_ptr_q;
   assign ret_rdidx  = vld_q[ret_ptr_q] ? rdidx_q[ret_ptr_q] : '0;
   assign ret_rdwen  = vld_q[ret_ptr_q] && rdwen_q[ret_ptr_q];
   assign oitf_empty = empty;
   assign oitf_full  = full;
   assign oitf_count = cnt_q;
   assign oitf_err   = err_q;

endmodule

// File: doc/exu_oitf_gen.md
# exu_oitf_gen

Parametrised outstanding-instruction tracking FIFO for the EXU, the next generation of the fixed-depth OITF. Records one entry per dispatched long-pipe instruction (LSU today, multi-cycle units later), hands its index to the unit as the instruction tag, and reports RAW/WAW hazards to dispatch. Entries retire in order under longp write-back control. New relative to the previous OITF: configurable depth and register-index width, pipeline flush, occupancy count, x0 hazard suppression and a sticky protocol-error flag.

## Interface
- DEPTH, 4, entry count; power of two, 2..16
- PTR_W, $clog2(DEPTH), tag/pointer width (derived, do not override)
- RFIDX_W, 5, register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_ena  in  1  allocate the entry at disp_ptr; honoured only when disp_ready=1
- disp_ready  out  1  FIFO not full
- disp_ptr  out  PTR_W  index the next allocation uses (itag for the unit)
- disp_i_rs1en, disp_i_rs2en, disp_i_rdwen  in  1 each  operand/dest enables of the instruction at dispatch
- disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx  in  RFIDX_W each  operand/dest indices
- oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd  out  1 each  hazard flags
- ret_ena  in  1  retire the oldest entry
- ret_ptr  out  PTR_W  index of the oldest entry
- ret_rdidx  out  RFIDX_W  rdidx of the oldest entry
- ret_rdwen  out  1  rdwen of the oldest entry
- flush_req  in  1  discard all entries
- oitf_empty, oitf_full  out  1 each  occupancy status
- oitf_count  out  PTR_W+1  valid entries, 0..DEPTH
- oitf_err  out  1  sticky protocol-violation flag

## Operation
- Circular buffer. Allocation pointer alc_ptr and retire pointer ret_ptr are PTR_W bits, each with a wrap flag that toggles when the pointer wraps DEPTH-1 -> 0.
- Empty: pointers and flags equal. Full: pointers equal, flags differ. disp_ready = !oitf_full. disp_ptr = alc_ptr.
- Per-entry registers: vld, rdwen, rdidx. Allocation writes vld=1, rdwen=disp_i_rdwen, rdidx=disp_i_rdidx at entry alc_ptr and advances alc_ptr. Retire clears vld at ret_ptr and advances ret_ptr.
- Hazards, all combinational from registered state:
  - oitfrd_match_disprs1 = OR over entries of (vld & rdwen & rdidx==disp_i_rs1idx) & disp_i_rs1en & (disp_i_rs1idx!=0).
  - rs2: same form. rd: same form using disp_i_rdwen.
  - x0 never matches.
- oitf_count is a registered counter: +1 on accepted allocation, -1 on accepted retire, unchanged when both occur.
- Priority:
  - flush_req clears all vld, both pointers, both flags and the count. Concurrent disp_ena and ret_ena are ignored. oitf_err is not cleared.
  - disp_ena while full: no allocation, state unchanged, oitf_err set.
  - ret_ena while empty: no retire, oitf_err set.
  - disp_ena and ret_ena in the same cycle when neither is blocked: both take effect.
  - At full, disp_ready is already 0, so the concurrent retire proceeds and the allocation is refused (err set).
- oitf_err is cleared only by reset.

## Timing
- Reset: all vld=0, pointers/flags=0, oitf_count=0, oitf_empty=1, oitf_full=0, disp_ready=1, disp_ptr=0, ret_ptr=0, ret_rdidx=0, ret_rdwen=0, oitf_err=0, match flags=0.
- Allocated entry becomes visible to hazard matching, count, empty and full on the cycle after disp_ena.
- The retiring entry still asserts matches in its retire cycle and stops the next cycle.
- ret_rdidx and ret_rdwen are a combinational read of entry ret_ptr. When empty they are 0.
- No combinational path from disp_ena or ret_ena to any output.

## Test plan
- Reset, then 4 allocations (DEPTH=4) with rdidx 1,2,3,4 -> disp_ptr 0,1,2,3; after the 4th edge oitf_full=1, disp_ready=0, count=4.
- Entry rdidx=5 rdwen=1 pending; dispatch rs1idx=5 rs1en=1 -> match_disprs1=1. Same with rs1en=0 -> 0. rdidx=0 entry with rs1idx=0 -> 0.
- Count=2, disp_ena and ret_ena together -> count stays 2, both pointers advance by 1, ret_rdidx shows the next-oldest entry.
- 6 allocate/retire pairs on DEPTH=4 -> pointers wrap 3->0, disp_ptr sequence 0,1,2,3,0,1, empty/full correct throughout.
- Count=3, flush_req with disp_ena=1 -> next cycle count=0, empty=1, disp_ptr=0, all match flags 0.
- ret_ena while empty -> oitf_err=1 and held. disp_ena while full -> err stays 1, count unchanged. Only rst_n low clears err.
